temp_sample_ctrl: RTL and testbench

Sequencing controller for the temperature sensor's ADC path. While enabled, it runs a burst of 2^AVG_LOG2 conversions once per period, using a start/done handshake with the ADC. It averages each burst, loads the result into a held output register, and pulses a valid strobe. It also flags conversions that never complete.

---
 rtl/temp_sample_ctrl.sv | 124 ++++++++++++
 tb/tb_temp_sample_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sample_ctrl.sv
// Temperature-sensor ADC sequencer: runs periodic bursts of 2^AVG_LOG2 conversions,
// averages each burst into a held output register and flags conversions that never finish.
module temp_sample_ctrl #(
   parameter int unsigned           DATA_WIDTH = 12,
   parameter int unsigned           AVG_LOG2   = 2,
   parameter int unsigned           PERIOD     = 1000,
   parameter int unsigned           TIMEOUT    = 255,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic                  adc_start,
   input  logic                  adc_done,
   input  logic [DATA_WIDTH-1:0] adc_data,
   output logic [DATA_WIDTH-1:0] temp_out,
   output logic                  temp_valid,
   output logic                  timeout_err,
   input  logic                  err_clr,
   output logic                  busy
);

   localparam int unsigned ACC_W  = DATA_WIDTH + AVG_LOG2;
   localparam int unsigned CNT_W  = AVG_LOG2 + 1;
   localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
   localparam int unsigned PCNT_W = $clog2(PERIOD + 1);

   localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST   = TCNT_W'(TIMEOUT - 1);
   localparam logic [PCNT_W-1:0] PCNT_LAST   = PCNT_W'(PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      CONV  = 2'd2,
      WAIT  = 2'd3
   } state_t;

   state_t              state;
   logic [ACC_W-1:0]    acc;
   logic [CNT_W-1:0]    cnt;
   logic [TCNT_W-1:0]   tcnt;
   logic [PCNT_W-1:0]   pcnt;
   logic [ACC_W-1:0]    sum;

   // Accumulator sized so a full burst of maximum samples cannot overflow.
   assign sum  = acc + ACC_W'(adc_data);
   assign busy = (state == START) || (state == CONV);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         adc_start   <= 1'b0;
         temp_valid  <= 1'b0;
         timeout_err <= 1'b0;
         temp_out    <= RESET_VAL;
         acc         <= '0;
         cnt         <= '0;
         tcnt        <= '0;
         pcnt        <= '0;
      end else begin
         // NOTE: with non-blocking assignments the last write in this block wins, so a
         // timeout set further down overrides the err_clr default here.
         adc_start  <= 1'b0;
         temp_valid <= 1'b0;
         if (err_clr)
            timeout_err <= 1'b0;

         unique case (state)
            IDLE: begin
               if (en) begin
                  acc       <= '0;
                  cnt       <= '0;
                  adc_start <= 1'b1;
                  state     <= START;
               end
            end

            START: begin
               tcnt  <= '0;
               state <= CONV;
            end

            CONV: begin
               if (adc_done) begin
                  acc <= sum;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST_SAMPLE) begin
                     temp_out   <= sum[ACC_W-1:AVG_LOG2];
                     temp_valid <= 1'b1;
                     pcnt       <= '0;
                     state      <= WAIT;
                  end else begin
                     adc_start <= 1'b1;
                     state     <= START;
                  end
               end else if (tcnt == TCNT_LAST) begin
                  timeout_err <= 1'b1;
                  pcnt        <= '0;
                  state       <= WAIT;
               end else begin
                  tcnt <= tcnt + TCNT_W'(1);
               end
            end

            WAIT: begin
               if (!en) begin
                  state <= IDLE;
               end else if (pcnt == PCNT_LAST) begin
                  acc       <= '0;
                  cnt       <= '0;
                  adc_start <= 1'b1;
                  state     <= START;
               end else begin
                  pcnt <= pcnt + PCNT_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Directed bench for temp_sample_ctrl: a table of averaging bursts plus hand-written
// sequences for reset, timeout, handshake and enable corner cases.
module tb_temp_sample_ctrl;

   localparam int unsigned DW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          adc_start;
   logic          adc_done;
   logic [DW-1:0] adc_data;
   logic [DW-1:0] temp_out;
   logic          temp_valid;
   logic          timeout_err;
   logic          err_clr;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   temp_sample_ctrl #(
      .DATA_WIDTH(DW),
      .AVG_LOG2  (2),
      .PERIOD    (8),
      .TIMEOUT   (16),
      .RESET_VAL ('0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .adc_start  (adc_start),
      .adc_done   (adc_done),
      .adc_data   (adc_data),
      .temp_out   (temp_out),
      .temp_valid (temp_valid),
      .timeout_err(timeout_err),
      .err_clr    (err_clr),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0][DW-1:0] s;
      logic [DW-1:0]      exp;
   } burst_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (adc_start !== 1'b1 && n < 64) begin
         step();
         n++;
      end
      check("start_wait_bound", 32'(n < 64), 32'd1);
   endtask

   task automatic do_conv(input logic [DW-1:0] data);
      int n;
      wait_start(n);
      repeat (3) step();
      adc_done = 1'b1;
      adc_data = data;
      step();
      adc_done = 1'b0;
      adc_data = '0;
   endtask

   // Called in the first WAIT cycle after the final sample.
   task automatic check_result(input string name, input logic [DW-1:0] exp);
      check({name, "_valid"}, 32'(temp_valid), 32'd1);
      check({name, "_temp"}, 32'(temp_out), 32'(exp));
      step();
      check({name, "_valid_pulse"}, 32'(temp_valid), 32'd0);
      check({name, "_temp_held"}, 32'(temp_out), 32'(exp));
   endtask

   task automatic count_to_start(output int n);
      n = 0;
      while (adc_start !== 1'b1 && n < 64) begin
         step();
         n++;
      end
   endtask

   task automatic count_starts(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (adc_start === 1'b1) n++;
      end
   endtask

   initial begin
      burst_vec_t vecs[5];
      int n;

      vecs[0].s = {12'd104, 12'd102, 12'd101, 12'd100}; vecs[0].exp = 12'd101;
      vecs[1].s = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}; vecs[1].exp = 12'hFFF;
      vecs[2].s = {12'd3,   12'd0,   12'd0,   12'd0};   vecs[2].exp = 12'd0;
      vecs[3].s = {12'd4,   12'd3,   12'd2,   12'd1};   vecs[3].exp = 12'd2;
      vecs[4].s = {12'd0,   12'd0,   12'd0,   12'd7};   vecs[4].exp = 12'd1;

      rst = 1'b1; en = 1'b0; adc_done = 1'b0; adc_data = '0; err_clr = 1'b0;
      repeat (2) step();
      check("rst_adc_start", 32'(adc_start), 32'd0);
      check("rst_temp_valid", 32'(temp_valid), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_temp_out", 32'(temp_out), 32'd0);
      rst = 1'b0;

      count_starts(20, n);
      check("idle_no_start", 32'(n), 32'd0);

      // en seen at the next edge, adc_start visible in the following cycle.
      en = 1'b1;
      step();
      check("en_start_latency", 32'(adc_start), 32'd1);
      check("start_busy", 32'(busy), 32'd1);

      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < 4; k++) do_conv(vecs[v].s[k]);
         check_result($sformatf("vec%0d", v), vecs[v].exp);
         count_to_start(n);
         check($sformatf("vec%0d_period_gap", v), 32'(n), 32'd7);
      end

      // Asynchronous reset in the middle of the third conversion.
      do_conv(12'd500);
      do_conv(12'd500);
      wait_start(n);
      step();
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_temp_out", 32'(temp_out), 32'd0);
      check("async_rst_adc_start", 32'(adc_start), 32'd0);
      check("async_rst_valid", 32'(temp_valid), 32'd0);
      en = 1'b0;
      step();
      rst = 1'b0;
      count_starts(30, n);
      check("post_rst_no_start", 32'(n), 32'd0);
      check("post_rst_no_valid", 32'(temp_valid), 32'd0);

      en = 1'b1;
      for (int k = 0; k < 3; k++) do_conv(12'd40);
      do_conv(12'd44);
      check_result("pre_timeout", 12'd41);
      count_to_start(n);
      check("pre_timeout_gap", 32'(n), 32'd7);

      // First timeout: no adc_done at all.
      repeat (16) step();
      check("to_not_yet_err", 32'(timeout_err), 32'd0);
      check("to_not_yet_busy", 32'(busy), 32'd1);
      step();
      check("to_err_set", 32'(timeout_err), 32'd1);
      check("to_no_valid", 32'(temp_valid), 32'd0);
      check("to_temp_kept", 32'(temp_out), 32'd41);
      check("to_busy_low", 32'(busy), 32'd0);
      count_to_start(n);
      check("to_period_gap", 32'(n), 32'd8);

      // Second timeout with err_clr in the same cycle: set must win.
      repeat (16) step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("to_set_beats_clr", 32'(timeout_err), 32'd1);

      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("err_clr_alone", 32'(timeout_err), 32'd0);
      count_to_start(n);

      // adc_done on the 16th CONV cycle is accepted rather than timing out.
      repeat (16) step();
      adc_done = 1'b1;
      adc_data = 12'd200;
      step();
      adc_done = 1'b0;
      check("done_last_cycle_no_err", 32'(timeout_err), 32'd0);
      check("done_last_cycle_next_start", 32'(adc_start), 32'd1);
      for (int k = 0; k < 3; k++) do_conv(12'd200);
      check_result("late_done", 12'd200);
      count_to_start(n);
      check("late_done_gap", 32'(n), 32'd7);

      // adc_done during START must be ignored.
      adc_done = 1'b1;
      adc_data = 12'd999;
      step();
      adc_done = 1'b0;
      check("start_done_ignored_busy", 32'(busy), 32'd1);
      check("start_done_ignored_no_start", 32'(adc_start), 32'd0);
      step();
      step();
      adc_done = 1'b1;
      adc_data = 12'd10;
      step();
      adc_done = 1'b0;
      do_conv(12'd10);
      do_conv(12'd10);
      do_conv(12'd14);
      check_result("start_done", 12'd11);
      count_to_start(n);
      check("start_done_gap", 32'(n), 32'd7);

      // Enable drops mid-burst: burst completes, then the controller parks in IDLE.
      do_conv(12'd20);
      do_conv(12'd20);
      en = 1'b0;
      do_conv(12'd20);
      do_conv(12'd24);
      check_result("en_drop", 12'd21);
      count_starts(30, n);
      check("en_drop_no_start", 32'(n), 32'd0);
      en = 1'b1;
      step();
      check("reenable_start", 32'(adc_start), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

endmodule
